// File: rtl/fir_serial_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_ctrl_pkg
// Purpose  : Shared definitions for the serial FIR controller: address-width
//            sizing function and FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fir_serial_ctrl_pkg;

  // Ceiling log2 used to size every address port. Never returns less than 1
  // so a degenerate single-tap filter still gets a legal 1-bit address.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  localparam int         c_ST_W     = 3;
  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_WRITE = 3'd1;
  localparam logic [2:0] c_ST_MAC   = 3'd2;
  localparam logic [2:0] c_ST_FLUSH = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fir_circ_addr.sv
`default_nettype none
// ============================================================================
// Module   : fir_circ_addr
// Purpose  : Circular delay-line addressing. Holds the mod-N write pointer
//            (newest sample slot) and computes the read address of tap k,
//            (ptr - k) mod N.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_adv        - advance pointer by one slot (wraps N-1 -> 0)
//            i_k          - tap index, must be < N
//            o_ptr        - current write pointer
//            o_rd_addr    - (o_ptr - i_k) mod N, combinational
// Revision : 1.0 - initial release
// ============================================================================
module fir_circ_addr #(
  parameter int N  = 17,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  input  logic [AW-1:0] i_k,
  output logic [AW-1:0] o_ptr,
  output logic [AW-1:0] o_rd_addr
);

  localparam logic [AW-1:0] c_LAST = AW'(N - 1);
  // N truncated to AW bits. Since the true result always lies in [0, N),
  // wrapping AW-bit arithmetic yields it exactly, even when N == 2**AW.
  localparam logic [AW-1:0] c_N_AW = AW'(N);

  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  always_comb begin
    w_rd_addr = r_ptr - i_k;
    if (r_ptr < i_k) begin
      w_rd_addr = r_ptr - i_k + c_N_AW;
    end
  end

  assign o_ptr     = r_ptr;
  assign o_rd_addr = w_rd_addr;

endmodule
`default_nettype wire

// File: rtl/fir_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_serial_ctrl
// Purpose  : Control unit for a single-MAC serial FIR filter. On each accepted
//            sample strobe it writes the delay line, walks coefficient ROM and
//            delay line in lockstep, drives the accumulator with the ROM's
//            one-cycle read latency absorbed, and flags the finished result.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_sample_valid    - one-cycle new-sample strobe
//            o_busy            - high in every state except IDLE
//            o_overrun         - pulse: a strobe was dropped while busy
//            o_we, o_wr_addr   - delay-line write enable / address
//            o_data_addr       - delay-line read address
//            o_coef_addr       - coefficient ROM address
//            o_acc_en          - MAC accumulate enable (aligned to read data)
//            o_acc_clr         - with o_acc_en: load instead of add
//            o_out_valid       - pulse: accumulator holds the finished output
// Revision : 1.0 - initial release
// ============================================================================
module fir_serial_ctrl
  import fir_serial_ctrl_pkg::*;
#(
  parameter  int NUM_COEF = 17,
  localparam int AW       = clog2(NUM_COEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_sample_valid,
  output logic          o_busy,
  output logic          o_overrun,
  output logic          o_we,
  output logic [AW-1:0] o_wr_addr,
  output logic [AW-1:0] o_data_addr,
  output logic [AW-1:0] o_coef_addr,
  output logic          o_acc_en,
  output logic          o_acc_clr,
  output logic          o_out_valid
);

  localparam logic [AW-1:0] c_K_LAST = AW'(NUM_COEF - 1);

  logic [c_ST_W-1:0] r_state;
  logic [c_ST_W-1:0] w_state_next;
  logic [AW-1:0]     r_k;

  logic              r_busy, r_overrun, r_we, r_acc_en, r_acc_clr, r_out_valid;
  logic [AW-1:0]     r_wr_addr, r_data_addr, r_coef_addr;

  logic              w_busy, w_overrun, w_we, w_acc_en, w_acc_clr, w_out_valid;
  logic              w_adv, w_addr_ld;
  logic [AW-1:0]     w_k_next;
  logic [AW-1:0]     w_ptr, w_rd_addr;

  fir_circ_addr #(
    .N  (NUM_COEF),
    .AW (AW)
  ) u_circ_addr (
    .clk       (clk),
    .rst       (rst),
    .i_adv     (w_adv),
    .i_k       (w_k_next),
    .o_ptr     (w_ptr),
    .o_rd_addr (w_rd_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = c_ST_IDLE;
    case (r_state)
      c_ST_IDLE:  w_state_next = i_sample_valid ? c_ST_WRITE : c_ST_IDLE;
      c_ST_WRITE: w_state_next = c_ST_MAC;
      c_ST_MAC:   w_state_next = (r_k == c_K_LAST) ? c_ST_FLUSH : c_ST_MAC;
      c_ST_FLUSH: w_state_next = c_ST_DONE;
      c_ST_DONE:  w_state_next = c_ST_IDLE;
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  // Output logic. Every output is registered, so values destined for the
  // next cycle are derived from the next state (or, for the accumulator
  // controls, from the current MAC state, which delays them by one cycle to
  // line up with the registered ROM/RAM read data).
  always_comb begin
    w_busy      = (w_state_next != c_ST_IDLE);
    w_we        = (w_state_next == c_ST_WRITE);
    w_out_valid = (w_state_next == c_ST_DONE);
    w_acc_en    = (r_state == c_ST_MAC);
    w_acc_clr   = (r_state == c_ST_MAC) && (r_k == '0);
    w_overrun   = i_sample_valid && (r_state != c_ST_IDLE);
    w_adv       = (r_state == c_ST_DONE);
    // Tap index presented during the next cycle; addresses only reload while
    // entering or stepping through MAC, otherwise they hold (and stay < N).
    w_k_next    = r_k;
    w_addr_ld   = 1'b0;
    if (r_state == c_ST_WRITE) begin
      w_k_next  = '0;
      w_addr_ld = 1'b1;
    end else if ((r_state == c_ST_MAC) && (r_k != c_K_LAST)) begin
      w_k_next  = r_k + 1'b1;
      w_addr_ld = 1'b1;
    end
  end

  // Tap counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_we        <= 1'b0;
      r_wr_addr   <= '0;
      r_data_addr <= '0;
      r_coef_addr <= '0;
      r_acc_en    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_k         <= w_k_next;
      r_busy      <= w_busy;
      r_overrun   <= w_overrun;
      r_we        <= w_we;
      r_acc_en    <= w_acc_en;
      r_acc_clr   <= w_acc_clr;
      r_out_valid <= w_out_valid;
      if (w_we) begin
        r_wr_addr <= w_ptr;
      end
      if (w_addr_ld) begin
        r_coef_addr <= w_k_next;
        r_data_addr <= w_rd_addr;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;
  assign o_we        = r_we;
  assign o_wr_addr   = r_wr_addr;
  assign o_data_addr = r_data_addr;
  assign o_coef_addr = r_coef_addr;
  assign o_acc_en    = r_acc_en;
  assign o_acc_clr   = r_acc_clr;
  assign o_out_valid = r_out_valid;

endmodule
`default_nettype wire
